// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start / 7-8 data / optional parity / 1-2 stop bits at a programmable baud divider.
// Define UART_TX_BUF_EN to add a 4-entry frame FIFO so that queued frames go out back-to-back.
module uart_tx_ctrl #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             dL,
  input  logic [1:0]       p,
  input  logic             s,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tx,
  output logic             busy,
  output logic             done,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int ENT_W = 12 + DIV_W;

  state_t           r_state;
  logic             r_armed;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitn;
  logic             r_len8;
  logic             r_par_en;
  logic             r_par_bit;
  logic             r_stop2;
  logic             r_stopn;

  logic             w_push;
  logic             w_launch;
  logic [ENT_W-1:0] w_in_ent;
  logic [ENT_W-1:0] w_src;
  logic             w_bit_end;
  logic             w_last_data;
  logic             w_last_cycle;

  // Handshake: a frame is taken on the rising edge where din_valid & din_ready are both high;
  // din, dL, p, s and baud_div are captured on that edge and the source may change afterwards.
  assign w_push       = din_valid & din_ready;
  assign w_in_ent     = {din, dL, p, s, baud_div};
  assign w_bit_end    = (r_cnt == r_div - DIV_W'(1));
  assign w_last_data  = (r_bitn == (r_len8 ? 3'd7 : 3'd6));
  assign w_last_cycle = (r_state == STOP) & w_bit_end & (~r_stop2 | r_stopn);

`ifdef UART_TX_BUF_EN
  logic [ENT_W-1:0] r_fifo [4];
  logic [1:0]       r_wp;
  logic [1:0]       r_rp;
  logic [2:0]       r_count;
  logic             w_empty;
  logic             w_pop;
  logic             w_wr;

  assign w_empty   = (r_count == 3'd0);
  assign din_ready = r_armed & tx_en & (r_count != 3'd4);
  assign w_src     = w_empty ? w_in_ent : r_fifo[r_rp];
  // A new frame may start from idle or directly in place of the final stop cycle.
  assign w_launch  = tx_en & ((r_state == IDLE) | w_last_cycle) & (~w_empty | w_push);
  assign w_pop     = w_launch & ~w_empty;
  assign w_wr      = w_push & ~(w_launch & w_empty);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 2'd1;
      if (w_pop) r_rp <= r_rp + 2'd1;
      r_count <= r_count + {2'b00, w_wr} - {2'b00, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_fifo[r_wp] <= w_in_ent;
  end
`else
  assign din_ready = r_armed & tx_en & (r_state == IDLE);
  assign w_src     = w_in_ent;
  assign w_launch  = w_push;
`endif

  logic [7:0]       w_src_din;
  logic             w_src_dl;
  logic [1:0]       w_src_p;
  logic             w_src_s;
  logic [DIV_W-1:0] w_src_div;
  logic [7:0]       w_data;

  assign w_src_din = w_src[DIV_W+11 -: 8];
  assign w_src_dl  = w_src[DIV_W+3];
  assign w_src_p   = w_src[DIV_W+2 -: 2];
  assign w_src_s   = w_src[DIV_W];
  assign w_src_div = w_src[DIV_W-1:0];
  assign w_data    = w_src_dl ? w_src_din : {1'b0, w_src_din[6:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_armed   <= 1'b0;
      r_cnt     <= '0;
      r_div     <= '0;
      r_shift   <= '0;
      r_bitn    <= '0;
      r_len8    <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_stop2   <= 1'b0;
      r_stopn   <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (!tx_en) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else if (w_launch) begin
        r_state   <= START;
        r_cnt     <= '0;
        r_div     <= (w_src_div == '0) ? DIV_W'(1) : w_src_div;
        r_shift   <= w_data;
        r_bitn    <= '0;
        r_len8    <= w_src_dl;
        r_par_en  <= w_src_p[0] ^ w_src_p[1];
        // Even parity repeats the data XOR; odd parity inverts it.
        r_par_bit <= (^w_data) ^ w_src_p[0];
        r_stop2   <= w_src_s;
        r_stopn   <= 1'b0;
      end else if (r_state != IDLE) begin
        if (!w_bit_end) begin
          r_cnt <= r_cnt + DIV_W'(1);
        end else begin
          r_cnt <= '0;
          case (r_state)
            START: r_state <= DATA;
            DATA: begin
              r_shift <= r_shift >> 1;
              r_bitn  <= r_bitn + 3'd1;
              if (w_last_data) r_state <= r_par_en ? PARITY : STOP;
            end
            PARITY: r_state <= STOP;
            STOP: begin
              if (r_stop2 && !r_stopn) r_stopn <= 1'b1;
              else                     r_state <= IDLE;
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    case (r_state)
      START:   tx = 1'b0;
      DATA:    tx = r_shift[0];
      PARITY:  tx = r_par_bit;
      default: tx = 1'b1;
    endcase
  end

  assign busy    = (r_state != IDLE);
  assign done    = w_last_cycle & tx_en;
  assign o_state = r_state;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frame shapes, parity, stop bits, reset and tx_en abort.
// Per-cycle line activity is collected into bit vectors (bit k = k-th cycle after accept).
module tb_uart_tx_ctrl;
  logic        clk;
  logic        rst;
  logic        tx_en;
  logic [7:0]  din;
  logic        din_valid;
  logic        dL;
  logic [1:0]  p;
  logic        s;
  logic [15:0] baud_div;
  wire         din_ready;
  wire         tx;
  wire         busy;
  wire         done;
  wire  [2:0]  o_state;

  int total = 0;
  int bad   = 0;

  logic [63:0] got_tx, got_done, got_busy, got_rdy;
  logic [63:0] exp_v;

  uart_tx_ctrl #(.DIV_W(16)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dL(dL), .p(p), .s(s), .baud_div(baud_div),
    .tx(tx), .busy(busy), .done(done), .o_state(o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // expected models
  function automatic logic [63:0] line_vec(input logic [11:0] bits, input int nbits, input int div);
    logic [63:0] v;
    v = '1;
    for (int k = 1; k < 64; k++) begin
      if ((k - 1) / div < nbits) v[k] = bits[(k - 1) / div];
    end
    return v;
  endfunction

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] v;
    v = '0;
    for (int k = lo; k <= hi; k++) v[k] = 1'b1;
    return v;
  endfunction

  // driver tasks
  task automatic send(input logic [7:0] d, input logic l, input logic [1:0] pp,
                      input logic ss, input logic [15:0] div);
    int waited;
    waited = 0;
    @(negedge clk);
    din = d; dL = l; p = pp; s = ss; baud_div = div; din_valid = 1'b1;
    while (din_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (din_ready !== 1'b1) begin
      $display("FAIL send_accept: din_ready=%b required 1", din_ready);
      bad++;
      din_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      din       = 8'($urandom_range(0, 255));
      dL        = ~l;
      p         = ~pp;
      s         = ~ss;
      baud_div  = 16'($urandom_range(1, 9));
    end
  endtask

  task automatic capture(input int n);
    got_tx = '1; got_done = '0; got_busy = '0; got_rdy = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      got_tx[k]   = tx;
      got_done[k] = done;
      got_busy[k] = busy;
      got_rdy[k]  = din_ready;
    end
  endtask

  // tests
  task automatic test_reset;
    #3;
    total++; if (tx !== 1'b1)        begin $display("FAIL rst_tx: got %b want 1", tx); bad++; end
    total++; if (busy !== 1'b0)      begin $display("FAIL rst_busy: got %b want 0", busy); bad++; end
    total++; if (done !== 1'b0)      begin $display("FAIL rst_done: got %b want 0", done); bad++; end
    total++; if (din_ready !== 1'b0) begin $display("FAIL rst_ready: got %b want 0", din_ready); bad++; end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (din_ready !== 1'b0) begin $display("FAIL rst_release_ready: got %b want 0", din_ready); bad++; end
    @(negedge clk);
    total++; if (din_ready !== 1'b1) begin $display("FAIL rst_first_edge_ready: got %b want 1", din_ready); bad++; end
  endtask

  task automatic test_odd_parity_8bit;
    // 0xAB, odd parity, 1 stop, 4 clk/bit: 0,1,1,0,1,0,1,0,1,0,1
    send(8'hAB, 1'b1, 2'b01, 1'b0, 16'd4);
    capture(46);
    exp_v = line_vec(12'b0101_0101_0110, 11, 4);
    total++; if (got_tx !== exp_v) begin $display("FAIL ab_tx: got %h want %h", got_tx, exp_v); bad++; end
    total++; if (got_done !== span(44, 44)) begin $display("FAIL ab_done: got %h want %h", got_done, span(44, 44)); bad++; end
    total++; if (got_busy !== span(1, 44)) begin $display("FAIL ab_busy: got %h want %h", got_busy, span(1, 44)); bad++; end
`ifndef UART_TX_BUF_EN
    total++; if (got_rdy !== span(45, 46)) begin $display("FAIL ab_ready: got %h want %h", got_rdy, span(45, 46)); bad++; end
`endif
  endtask

  task automatic test_7bit_two_stop;
    // 0x6D as 7 bits, no parity, 2 stops, 2 clk/bit: 0,1,0,1,1,0,1,1,1,1
    send(8'h6D, 1'b0, 2'b00, 1'b1, 16'd2);
    capture(22);
    exp_v = line_vec(12'b0011_1101_1010, 10, 2);
    total++; if (got_tx !== exp_v) begin $display("FAIL 6d_tx: got %h want %h", got_tx, exp_v); bad++; end
    total++; if (got_done !== span(20, 20)) begin $display("FAIL 6d_done: got %h want %h", got_done, span(20, 20)); bad++; end
    total++; if (got_busy !== span(1, 20)) begin $display("FAIL 6d_busy: got %h want %h", got_busy, span(1, 20)); bad++; end
  endtask

  task automatic test_parity_even_odd;
    // 0xFF 7-bit even parity -> parity 1
    send(8'hFF, 1'b0, 2'b10, 1'b1, 16'd1);
    capture(13);
    exp_v = line_vec(12'b0111_1111_1110, 11, 1);
    total++; if (got_tx !== exp_v) begin $display("FAIL ff_even_tx: got %h want %h", got_tx, exp_v); bad++; end
    total++; if (got_done !== span(11, 11)) begin $display("FAIL ff_even_done: got %h want %h", got_done, span(11, 11)); bad++; end
    // same with odd parity -> parity 0; baud_div 0 behaves as 1
    send(8'hFF, 1'b0, 2'b01, 1'b1, 16'd0);
    capture(13);
    exp_v = line_vec(12'b0110_1111_1110, 11, 1);
    total++; if (got_tx !== exp_v) begin $display("FAIL ff_odd_tx: got %h want %h", got_tx, exp_v); bad++; end
    total++; if (got_done !== span(11, 11)) begin $display("FAIL ff_odd_done: got %h want %h", got_done, span(11, 11)); bad++; end
    total++; if (got_busy !== span(1, 11)) begin $display("FAIL ff_odd_busy: got %h want %h", got_busy, span(1, 11)); bad++; end
  endtask

  task automatic test_reset_mid_frame;
    logic saw_done;
    send(8'hAB, 1'b1, 2'b01, 1'b0, 16'd4);
    repeat (14) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    total++; if (tx !== 1'b1)   begin $display("FAIL midrst_tx: got %b want 1", tx); bad++; end
    total++; if (busy !== 1'b0) begin $display("FAIL midrst_busy: got %b want 0", busy); bad++; end
    saw_done = done;
    repeat (2) begin
      @(negedge clk);
      saw_done |= done;
    end
    rst = 1'b1;
    @(negedge clk);
    saw_done |= done;
    total++; if (saw_done !== 1'b0) begin $display("FAIL midrst_no_done: got %b want 0", saw_done); bad++; end
    total++; if (din_ready !== 1'b1) begin $display("FAIL midrst_ready: got %b want 1", din_ready); bad++; end
    send(8'h6D, 1'b0, 2'b00, 1'b1, 16'd2);
    capture(22);
    exp_v = line_vec(12'b0011_1101_1010, 10, 2);
    total++; if (got_tx !== exp_v) begin $display("FAIL midrst_next_tx: got %h want %h", got_tx, exp_v); bad++; end
    total++; if (got_done !== span(20, 20)) begin $display("FAIL midrst_next_done: got %h want %h", got_done, span(20, 20)); bad++; end
  endtask

  task automatic test_tx_en_abort;
    logic [3:0] seen;
    send(8'hAB, 1'b1, 2'b01, 1'b0, 16'd4);
    repeat (10) @(negedge clk);
    tx_en = 1'b0;
    #1;
    total++; if (din_ready !== 1'b0) begin $display("FAIL txen_ready_drop: got %b want 0", din_ready); bad++; end
    seen = 4'b1000;   // {tx, busy, done, din_ready} expected 1,0,0,0
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if ({tx, busy, done, din_ready} !== 4'b1000) seen = {tx, busy, done, din_ready};
    end
    total++; if (seen !== 4'b1000) begin $display("FAIL txen_low_state: got %b want 1000", seen); bad++; end
    tx_en = 1'b1;
    seen = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if ({tx, busy, done, 1'b0} !== 4'b1000) seen = {tx, busy, done, 1'b0};
    end
    total++; if (seen !== 4'b1000) begin $display("FAIL txen_no_restart: got %b want 1000", seen); bad++; end
    total++; if (din_ready !== 1'b1) begin $display("FAIL txen_ready_back: got %b want 1", din_ready); bad++; end
    send(8'hFF, 1'b0, 2'b10, 1'b1, 16'd1);
    capture(13);
    exp_v = line_vec(12'b0111_1111_1110, 11, 1);
    total++; if (got_tx !== exp_v) begin $display("FAIL txen_next_tx: got %h want %h", got_tx, exp_v); bad++; end
  endtask

`ifdef UART_TX_BUF_EN
  task automatic test_back_to_back;
    logic [9:0] frames [5];
    logic [7:0] data [5];
    logic       acc;
    int         nacc;
    frames[0] = 10'b10_0000_0000;
    frames[1] = 10'b11_1111_1110;
    frames[2] = 10'b10_1010_1010;
    frames[3] = 10'b10_1010_1010;
    frames[4] = 10'b10_1010_1010;
    data[0] = 8'h00; data[1] = 8'hFF; data[2] = 8'h55; data[3] = 8'h55; data[4] = 8'h55;
    nacc = 0;
    got_tx = '1; got_done = '0; got_busy = '0; got_rdy = '0;
    @(negedge clk);
    din = data[0]; dL = 1'b1; p = 2'b00; s = 1'b0; baud_div = 16'd1; din_valid = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      acc = din_valid & din_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        nacc++;
        if (nacc < 5) din = data[nacc];
        else          din_valid = 1'b0;
      end
      @(negedge clk);
      got_tx[k] = tx; got_done[k] = done; got_busy[k] = busy; got_rdy[k] = din_ready;
    end
    exp_v = '1;
    for (int k = 1; k <= 50; k++) exp_v[k] = frames[(k - 1) / 10][(k - 1) % 10];
    total++; if (nacc != 5) begin $display("FAIL b2b_accepts: got %0d want 5", nacc); bad++; end
    total++; if (got_tx !== exp_v) begin $display("FAIL b2b_tx: got %h want %h", got_tx, exp_v); bad++; end
    exp_v = span(10, 10) | span(20, 20) | span(30, 30) | span(40, 40) | span(50, 50);
    total++; if (got_done !== exp_v) begin $display("FAIL b2b_done: got %h want %h", got_done, exp_v); bad++; end
    total++; if (got_busy !== span(1, 50)) begin $display("FAIL b2b_busy: got %h want %h", got_busy, span(1, 50)); bad++; end
    exp_v = span(1, 4) | span(11, 55);
    total++; if (got_rdy !== exp_v) begin $display("FAIL b2b_ready: got %h want %h", got_rdy, exp_v); bad++; end
  endtask
`else
  task automatic test_back_to_back;
    send(8'h00, 1'b1, 2'b00, 1'b0, 16'd1);
    capture(10);
    exp_v = line_vec(12'b0010_0000_0000, 10, 1);
    total++; if (got_tx !== exp_v) begin $display("FAIL b2b_first_tx: got %h want %h", got_tx, exp_v); bad++; end
    total++; if (got_rdy !== 64'd0) begin $display("FAIL b2b_ready_busy: got %h want 0", got_rdy); bad++; end
    send(8'h55, 1'b1, 2'b00, 1'b0, 16'd1);
    capture(12);
    exp_v = line_vec(12'b0010_1010_1010, 10, 1);
    total++; if (got_tx !== exp_v) begin $display("FAIL b2b_second_tx: got %h want %h", got_tx, exp_v); bad++; end
    total++; if (got_done !== span(10, 10)) begin $display("FAIL b2b_second_done: got %h want %h", got_done, span(10, 10)); bad++; end
  endtask
`endif

  initial begin
    rst = 1'b0; tx_en = 1'b1; din_valid = 1'b0;
    din = 8'h00; dL = 1'b1; p = 2'b00; s = 1'b0; baud_div = 16'd1;
    test_reset();
    test_odd_parity_8bit();
    test_7bit_two_stop();
    test_parity_even_odd();
    test_reset_mid_frame();
    test_tx_en_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
